// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the burst memory controller.
// The optional wrap-check feature is controlled by MEM_BURST_WRAP_CHECK_EN
// in mem_burst_ctrl.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      RESP
   } state_t;

   localparam int DEF_ADDR_W        = 8;
   localparam int DEF_DATA_W        = 8;
   localparam int DEF_LEN_W         = 4;
   localparam int DEF_RD_FIFO_DEPTH = 4;

endpackage

// File: rtl/mc_rd_fifo.sv
// Small synchronous FIFO holding read data returned by the memory core.
// First-word fall-through: pop_data always shows the head entry.
module mc_rd_fifo #(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 8,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic [CNT_W-1:0]  count,
   output logic              empty
);

   logic [DATA_W-1:0] storage [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty    = (count == '0);
   assign do_push  = push && (count != CNT_W'(DEPTH));
   assign do_pop   = pop && !empty;
   assign pop_data = storage[rd_ptr];

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Data storage needs no reset; only entries behind the pointers are ever read
   always_ff @(posedge clk) begin
      if (do_push)
         storage[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller in front of a single-port 256x8 memory core.
// Define MEM_BURST_WRAP_CHECK_EN to reject bursts that would cross the top
// of the address space; otherwise such bursts wrap to address 0.
module mem_burst_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int LEN_W         = DEF_LEN_W,
   parameter int RD_FIFO_DEPTH = DEF_RD_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   input  logic              rdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic              ce_mem,
   output logic              we_mem,
   output logic [ADDR_W-1:0] addr_mem,
   output logic [DATA_W-1:0] datai_mem,
   input  logic [DATA_W-1:0] datao_mem
);

   localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] addr_cnt;
   logic [LEN_W-1:0]  beat_cnt;
   logic              accept;
   logic              issue_wr;
   logic              issue_rd;
   logic              ce_rd;
   logic              rd_pipe;
   logic [1:0]        inflight;
   logic [CNT_W:0]    occupancy;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              pop;

   // A read occupies one cycle on the core and one cycle of returned data before
   // it lands in the FIFO; both stages count against the FIFO space.
   assign ce_rd       = ce_mem & ~we_mem;
   assign inflight    = {1'b0, ce_rd} + {1'b0, rd_pipe};
   assign occupancy   = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight);
   assign rdata_valid = ~fifo_empty;
   assign pop         = rdata_valid & rdata_ready;

`ifdef MEM_BURST_WRAP_CHECK_EN
   logic wrap_violation;
   logic err_q;

   assign wrap_violation = ({1'b0, cmd_addr} + (ADDR_W + 1)'(cmd_len))
                           > (ADDR_W + 1)'((1 << ADDR_W) - 1);
   assign resp_err       = resp_valid & err_q;

   // Remember whether the accepted command was rejected, for the response
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if (accept)
         err_q <= wrap_violation;
   end
`else
   assign resp_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic and handshake outputs
   always_comb begin
      next_state  = state;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      resp_valid  = 1'b0;
      accept      = 1'b0;
      issue_wr    = 1'b0;
      issue_rd    = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept = 1'b1;
`ifdef MEM_BURST_WRAP_CHECK_EN
               if (wrap_violation)
                  next_state = RESP;
               else
`endif
               if (cmd_we)
                  next_state = WRITE;
               else
                  next_state = READ;
            end
         end
         WRITE: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               issue_wr = 1'b1;
               if (beat_cnt == '0)
                  next_state = RESP;
            end
         end
         READ: begin
            if (occupancy < (CNT_W + 1)'(RD_FIFO_DEPTH)) begin
               issue_rd = 1'b1;
               if (beat_cnt == '0)
                  next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (rd_pipe && !ce_rd)
               next_state = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Burst counters and registered core interface; address and data hold when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_cnt  <= '0;
         beat_cnt  <= '0;
         ce_mem    <= 1'b0;
         we_mem    <= 1'b0;
         addr_mem  <= '0;
         datai_mem <= '0;
         rd_pipe   <= 1'b0;
      end else begin
         ce_mem  <= issue_wr | issue_rd;
         we_mem  <= issue_wr;
         rd_pipe <= ce_rd;
         if (accept) begin
            addr_cnt <= cmd_addr;
            beat_cnt <= cmd_len;
         end else if (issue_wr || issue_rd) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            beat_cnt <= beat_cnt - LEN_W'(1);
            addr_mem <= addr_cnt;
         end
         if (issue_wr)
            datai_mem <= wdata;
      end
   end

   mc_rd_fifo #(
      .DEPTH  (RD_FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_rd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pipe),
      .push_data (datao_mem),
      .pop       (pop),
      .pop_data  (rdata),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl with a behavioural 256x8 memory core.
// Build with MEM_BURST_WRAP_CHECK_EN defined to exercise burst rejection.
module tb_mem_burst_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_we;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_len;
   logic       wdata_valid;
   logic       wdata_ready;
   logic [7:0] wdata;
   logic       rdata_valid;
   logic       rdata_ready;
   logic [7:0] rdata;
   logic       resp_valid;
   logic       resp_err;
   logic       ce_mem;
   logic       we_mem;
   logic [7:0] addr_mem;
   logic [7:0] datai_mem;
   logic [7:0] datao_mem;

   logic [7:0]  mem_model [256];
   logic [7:0]  rd_q [$];
   logic [15:0] wr_q [$];
   logic        resp_q [$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          resp_seen   = 0;
   int          exp_resp    = 0;

   mem_burst_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_we      (cmd_we),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .rdata_valid (rdata_valid),
      .rdata_ready (rdata_ready),
      .rdata       (rdata),
      .resp_valid  (resp_valid),
      .resp_err    (resp_err),
      .ce_mem      (ce_mem),
      .we_mem      (we_mem),
      .addr_mem    (addr_mem),
      .datai_mem   (datai_mem),
      .datao_mem   (datao_mem)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input logic [7:0] a);
      return a ^ 8'hC3;
   endfunction

   // Memory core model: registered read data, write on ce&we
   always @(posedge clk) begin
      if (ce_mem) begin
         if (we_mem)
            mem_model[addr_mem] <= datai_mem;
         else
            datao_mem <= mem_model[addr_mem];
      end
   end

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Read-return monitor
   always @(negedge clk) begin
      if (rdata_valid && rdata_ready) begin
         if (rd_q.size() == 0)
            check_output("rdata_unexpected", 16'(rdata), 16'h1FF);
         else
            check_output("rdata", 16'(rdata), 16'(rd_q.pop_front()));
      end
   end

   // Core write-access monitor
   always @(negedge clk) begin
      if (ce_mem && we_mem) begin
         if (wr_q.size() == 0)
            check_output("write_unexpected", {addr_mem, datai_mem}, 16'hFFFF);
         else
            check_output("write_access", {addr_mem, datai_mem}, wr_q.pop_front());
      end
   end

   // Response monitor
   always @(negedge clk) begin
      if (resp_valid) begin
         resp_seen++;
         if (resp_q.size() == 0)
            check_output("resp_unexpected", 16'(resp_err), 16'h2);
         else
            check_output("resp_err", 16'(resp_err), 16'(resp_q.pop_front()));
      end
   end

   task automatic apply_stimulus(input logic we, input logic [7:0] addr, input logic [3:0] len);
      bit done = 1'b0;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = addr;
      cmd_len   = len;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = cmd_ready;
         @(posedge clk);
      end
      #1 cmd_valid = 1'b0;
      if (!done)
         check_output("cmd_accept_timeout", 16'd0, 16'd1);
   endtask

   task automatic send_beat(input logic [7:0] d);
      bit done = 1'b0;
      wdata_valid = 1'b1;
      wdata       = d;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = wdata_ready;
         @(posedge clk);
      end
      #1 wdata_valid = 1'b0;
      if (!done)
         check_output("wdata_accept_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_resp(input int n);
      for (int i = 0; i < 300 && resp_seen < n; i++)
         @(posedge clk);
      #1;
      if (resp_seen < n)
         check_output("resp_timeout", 16'(resp_seen), 16'(n));
   endtask

   task automatic expect_read(input logic [7:0] addr, input int beats);
      for (int i = 0; i < beats; i++)
         rd_q.push_back(init_val(addr + 8'(i)));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int ce_cnt;
      int resp_cyc;
      int acc_cyc;
      for (int i = 0; i < 256; i++)
         mem_model[i] = init_val(8'(i));
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_we      = 1'b0;
      cmd_addr    = '0;
      cmd_len     = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      rdata_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check_output("rst_cmd_ready", 16'(cmd_ready), 16'd1);
      check_output("rst_ce_we", {14'd0, ce_mem, we_mem}, 16'd0);
      check_output("rst_addr_data", {addr_mem, datai_mem}, 16'd0);
      check_output("rst_outs", {12'd0, wdata_ready, rdata_valid, resp_valid, resp_err}, 16'd0);
      @(posedge clk);
      #1;

      // Test 1: single-beat write then read back
      $display("[TB] test 1");
      wr_q.push_back({8'h10, 8'hA5});
      resp_q.push_back(1'b0);
      exp_resp++;
      apply_stimulus(1'b1, 8'h10, 4'd0);
      send_beat(8'hA5);
      wait_resp(exp_resp);
      rd_q.push_back(8'hA5);
      resp_q.push_back(1'b0);
      exp_resp++;
      apply_stimulus(1'b0, 8'h10, 4'd0);
      wait_resp(exp_resp);

`ifdef MEM_BURST_WRAP_CHECK_EN
      // Test 3: crossing burst is rejected with no core traffic
      $display("[TB] test 3");
      resp_q.push_back(1'b1);
      exp_resp++;
      apply_stimulus(1'b1, 8'hFE, 4'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("rej_wdata_ready", 16'(wdata_ready), 16'd0);
         check_output("rej_ce_mem", 16'(ce_mem), 16'd0);
      end
      @(posedge clk);
      #1;
      wait_resp(exp_resp);
`else
      // Test 2: write burst wrapping past 0xFF, then read back
      $display("[TB] test 2");
      wr_q.push_back({8'hFE, 8'h11});
      wr_q.push_back({8'hFF, 8'h22});
      wr_q.push_back({8'h00, 8'h33});
      wr_q.push_back({8'h01, 8'h44});
      resp_q.push_back(1'b0);
      exp_resp++;
      apply_stimulus(1'b1, 8'hFE, 4'd3);
      send_beat(8'h11);
      send_beat(8'h22);
      send_beat(8'h33);
      send_beat(8'h44);
      wait_resp(exp_resp);
      rd_q.push_back(8'h11);
      rd_q.push_back(8'h22);
      rd_q.push_back(8'h33);
      rd_q.push_back(8'h44);
      resp_q.push_back(1'b0);
      exp_resp++;
      apply_stimulus(1'b0, 8'hFE, 4'd3);
      wait_resp(exp_resp);
`endif

      // Test 4: 16-beat read with stalled consumer limits outstanding reads to 4
      $display("[TB] test 4");
      rdata_ready = 1'b0;
      expect_read(8'h20, 16);
      resp_q.push_back(1'b0);
      exp_resp++;
      apply_stimulus(1'b0, 8'h20, 4'd15);
      ce_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ce_mem)
            ce_cnt++;
      end
      check_output("stall_ce_pulses", 16'(ce_cnt), 16'd4);
      check_output("stall_rdata_valid", 16'(rdata_valid), 16'd1);
      @(posedge clk);
      #1 rdata_ready = 1'b1;
      wait_resp(exp_resp);

      // Test 5: command held during a burst is accepted the cycle after RESP
      $display("[TB] test 5");
      expect_read(8'h30, 4);
      resp_q.push_back(1'b0);
      resp_q.push_back(1'b0);
      wr_q.push_back({8'h40, 8'h77});
      exp_resp += 2;
      apply_stimulus(1'b0, 8'h30, 4'd3);
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 8'h40;
      cmd_len   = 4'd0;
      resp_cyc  = -10;
      acc_cyc   = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (resp_valid)
            resp_cyc = i;
         if (cmd_ready) begin
            acc_cyc = i;
            break;
         end
      end
      check_output("held_cmd_accept_cycle", 16'(acc_cyc), 16'(resp_cyc + 1));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      send_beat(8'h77);
      wait_resp(exp_resp);

      // Test 6: reset in the middle of a write burst
      $display("[TB] test 6");
      wr_q.push_back({8'h50, 8'hAA});
      wr_q.push_back({8'h51, 8'hBB});
      apply_stimulus(1'b1, 8'h50, 4'd3);
      send_beat(8'hAA);
      send_beat(8'hBB);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_output("abort_cmd_ready", 16'(cmd_ready), 16'd1);
      check_output("abort_ce_we", {14'd0, ce_mem, we_mem}, 16'd0);
      check_output("abort_addr_data", {addr_mem, datai_mem}, 16'd0);
      check_output("abort_outs", {12'd0, wdata_ready, rdata_valid, resp_valid, resp_err}, 16'd0);
      @(posedge clk);
      #1;
      rd_q.push_back(8'hAA);
      rd_q.push_back(8'hBB);
      expect_read(8'h52, 2);
      resp_q.push_back(1'b0);
      exp_resp++;
      apply_stimulus(1'b0, 8'h50, 4'd3);
      wait_resp(exp_resp);

      // Drain and confirm every expectation was consumed
      for (int i = 0; i < 100 && rd_q.size() != 0; i++)
         @(posedge clk);
      repeat (3) @(posedge clk);
      check_output("rd_q_left", 16'(rd_q.size()), 16'd0);
      check_output("wr_q_left", 16'(wr_q.size()), 16'd0);
      check_output("resp_q_left", 16'(resp_q.size()), 16'd0);
      check_output("resp_count", 16'(resp_seen), 16'(exp_resp));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
